// File: rtl/fabric_config_loader.sv
// rtl/fabric_config_loader.sv - walks every fabric configuration target, copies one ROM word
// per target onto the select/write-enable bus, then enables the fabric.
module fabric_config_loader #(
    parameter int N_TARGETS = 41,
    parameter int ADDR_W    = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [ADDR_W-1:0] cfg_sel,
    output logic [32:0]       cfg_data,
    output logic              cfg_we,
    output logic              busy,
    output logic              done,
    output logic              fabric_en
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TARGETS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] cfg_sel_q, cfg_sel_d;
    logic [32:0]       cfg_data_q, cfg_data_d;
    logic              fabric_en_q, fabric_en_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cfg_sel_d   = cfg_sel_q;
        cfg_data_d  = cfg_data_q;
        fabric_en_d = fabric_en_q;
        case (state_q)
            S_IDLE: begin
                // A new pass always disables the fabric until every target is rewritten.
                if (start) begin
                    state_d     = S_ISSUE;
                    idx_d       = '0;
                    fabric_en_d = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_WRITE;
                    cfg_data_d = {1'b0, rom_data};
                    cfg_sel_d  = idx_q;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    idx_d   = idx_q + IDX_ONE;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                fabric_en_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cfg_sel_q   <= '0;
            cfg_data_q  <= '0;
            fabric_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cfg_sel_q   <= cfg_sel_d;
            cfg_data_q  <= cfg_data_d;
            fabric_en_q <= fabric_en_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset clears them at once.
    assign rom_en    = (state_q == S_ISSUE);
    assign rom_addr  = idx_q;
    assign cfg_we    = (state_q == S_WRITE);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign cfg_sel   = cfg_sel_q;
    assign cfg_data  = cfg_data_q;
    assign fabric_en = fabric_en_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// tb/tb_fabric_config_loader.sv - directed scoreboard bench for fabric_config_loader.
module tb_fabric_config_loader;

    localparam int NT = 41;

    logic        clock = 1'b0;
    logic        reset_n, start, abort;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [5:0]  cfg_sel;
    logic [32:0] cfg_data;
    logic        cfg_we, busy, done, fabric_en;

    logic        start_1, abort_1;
    logic        rom_en_1;
    logic [5:0]  rom_addr_1;
    logic [31:0] rom_data_1;
    logic [5:0]  cfg_sel_1;
    logic [32:0] cfg_data_1;
    logic        cfg_we_1, busy_1, done_1, fabric_en_1;

    always #5 clock = ~clock;

    fabric_config_loader #(.N_TARGETS(NT), .ADDR_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_we(cfg_we),
        .busy(busy), .done(done), .fabric_en(fabric_en)
    );

    fabric_config_loader #(.N_TARGETS(1), .ADDR_W(6)) dut_1 (
        .clock(clock), .reset_n(reset_n), .start(start_1), .abort(abort_1),
        .rom_en(rom_en_1), .rom_addr(rom_addr_1), .rom_data(rom_data_1),
        .cfg_sel(cfg_sel_1), .cfg_data(cfg_data_1), .cfg_we(cfg_we_1),
        .busy(busy_1), .done(done_1), .fabric_en(fabric_en_1)
    );

    logic [31:0] mem [0:63];

    always @(posedge clock) begin
        if (rom_en) rom_data <= mem[rom_addr];
        if (rom_en_1) rom_data_1 <= 32'h1234_5678;
    end

    typedef struct {
        logic [5:0]  sel;
        logic [32:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq [$];
    int   vec = 0;
    int   errs = 0;
    int   cyc = 0;
    int   s_edge = 0;
    int   exp_done = -1;
    int   busy_cnt = 0;
    logic done_seen = 1'b0;
    logic fab_exp = 1'b0;
    logic fab_set_pending = 1'b0;
    logic fab_clr_pending = 1'b0;

    function automatic logic [31:0] rom_word(input int i);
        if (i == 0)       return 32'h0000_0000;
        else if (i <= 8)  return 32'hFF00_F0F0;
        else if (i <= 12) return 32'hFAFA_A0A0;
        else              return 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expectations are timed from the edge that will sample start next.
    task automatic start_pass(input int n_we, input logic full);
        exp_t e;
        s_edge = cyc + 1;
        for (int i = 0; i < n_we; i++) begin
            e.sel  = 6'(i);
            e.data = {1'b0, rom_word(i)};
            e.cyc  = s_edge + 3 * i + 2;
            sbq.push_back(e);
        end
        exp_done        = full ? s_edge + 3 * NT : -1;
        fab_clr_pending = 1'b1;
        busy_cnt        = 0;
        done_seen       = 1'b0;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clock);
        cyc++;
        if (fab_set_pending) begin fab_exp = 1'b1; fab_set_pending = 1'b0; end
        if (fab_clr_pending) begin fab_exp = 1'b0; fab_clr_pending = 1'b0; end
        @(negedge clock);
        check("fabric_en", fabric_en, fab_exp);
        if (busy) busy_cnt++;
        if (cfg_we) begin
            if (sbq.size() == 0) begin
                check("unexpected_cfg_we", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("we_sel", cfg_sel, e.sel);
                check("we_data", cfg_data, e.data);
                check("we_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            check("done_cycle", cyc, exp_done);
            exp_done        = -1;
            done_seen       = 1'b1;
            fab_set_pending = 1'b1;
        end
    endtask

    task automatic run_pass();
        int b = 0;
        while (!done_seen && b < 200) begin
            step();
            b++;
        end
        check("pass_done_seen", done_seen, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_en"}, rom_en, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_cfg_sel"}, cfg_sel, 0);
        check({tag, "_cfg_data"}, cfg_data, 0);
        check({tag, "_cfg_we"}, cfg_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fabric_en"}, fabric_en, 0);
    endtask

    initial begin
        int we_n;
        int dn_n;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        start_1 = 1'b0; abort_1 = 1'b0;
        rom_data = '0; rom_data_1 = '0;
        for (int i = 0; i < 64; i++) mem[i] = rom_word(i);

        step(); step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Single pulsed pass over every target.
        start_pass(NT, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        run_pass();
        check("busy_cycles", busy_cnt, 123);
        check("sb_empty_pass1", sbq.size(), 0);
        step();
        check("fabric_en_after_done", fabric_en, 1);
        repeat (3) step();

        // start held high: one pass, then a restart from the IDLE cycle after DONE.
        start_pass(NT, 1'b1);
        start = 1'b1; step();
        run_pass();
        step();
        check("held_idle_fabric_en", fabric_en, 1);
        start_pass(NT, 1'b1);
        step();
        start = 1'b0;
        check("restart_fabric_drop", fabric_en, 0);
        run_pass();
        check("sb_empty_held", sbq.size(), 0);
        repeat (3) step();

        // Abort while capturing target 10.
        start_pass(10, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        while (cyc < s_edge + 31) step();
        check("abort_pre_busy", busy, 1);
        check("abort_pre_we", cfg_we, 0);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_rom_en", rom_en, 0);
        check("abort_idle_we", cfg_we, 0);
        repeat (10) step();
        check("sb_empty_abort", sbq.size(), 0);
        check("abort_fabric_en", fabric_en, 0);

        // Asynchronous reset inside the WRITE cycle of target 20.
        start_pass(21, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        while (cyc < s_edge + 62) step();
        check("mid_write_we", cfg_we, 1);
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sbq.delete();
        fab_exp = 1'b0; fab_set_pending = 1'b0; fab_clr_pending = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
        start_pass(NT, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        run_pass();
        check("sb_empty_after_reset", sbq.size(), 0);
        step();

        // Single-target build.
        we_n = 0; dn_n = 0;
        @(negedge clock);
        start_1 = 1'b1;
        @(posedge clock);
        #1 start_1 = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            if (cfg_we_1) begin
                we_n++;
                check("n1_we_sel", cfg_sel_1, 0);
                check("n1_we_data", cfg_data_1, 33'h0_1234_5678);
                check("n1_we_cycle", t, 2);
            end
            if (done_1) begin
                dn_n++;
                check("n1_done_cycle", t, 3);
            end
            if (t == 4) check("n1_fabric_en", fabric_en_1, 1);
            @(posedge clock);
        end
        check("n1_we_count", we_n, 1);
        check("n1_done_count", dn_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
